capture_ctrl: RTL and testbench

//   Acquisition sequencer between packer8to32 and the host-side word FIFO.

---
 rtl/capture_ctrl_if.sv | 10 +
 rtl/capture_ctrl.sv | 88 ++++++++
 tb/tb_capture_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: packed input stream and FIFO write port of the capture sequencer
interface capture_ctrl_if #(parameter int DATA_LEN = 32);
  logic                in_valid;
  logic [DATA_LEN-1:0] in_data;
  logic                fifo_full;
  logic                fifo_wr;
  logic [DATA_LEN-1:0] fifo_data;
  modport master (input in_valid, in_data, fifo_full, output fifo_wr, fifo_data);
  modport slave  (output in_valid, in_data, fifo_full, input fifo_wr, fifo_data);
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: arms on command, waits for a masked trigger word, forwards cfg_len words to the FIFO
module capture_ctrl #(
  parameter int DATA_LEN = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cmd_arm,
  input  logic                i_cmd_abort,
  input  logic [DATA_LEN-1:0] i_cfg_trig_val,
  input  logic [DATA_LEN-1:0] i_cfg_trig_mask,
  input  logic [CNT_W-1:0]    i_cfg_len,
  capture_ctrl_if.master      bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic [CNT_W-1:0]    o_word_cnt
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t              r_state;
  logic [DATA_LEN-1:0] r_val, r_mask, r_fifo_data;
  logic [CNT_W-1:0]    r_len, r_cnt;
  logic                r_fifo_wr, r_done, r_ovf;
  logic                w_hit;
  logic [CNT_W-1:0]    w_cnt_nxt;
  assign w_hit        = bus.in_valid && ((bus.in_data ^ r_val) & r_mask) == '0;
  assign w_cnt_nxt    = r_cnt + 1'b1;
  assign o_busy       = r_state == ARMED || r_state == CAPTURE;
  assign o_done       = r_done;
  assign o_overflow   = r_ovf;
  assign o_word_cnt   = r_cnt;
  assign bus.fifo_wr   = r_fifo_wr;
  assign bus.fifo_data = r_fifo_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_val       <= '0;
      r_mask      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_fifo_wr <= 1'b0;
      // abort outranks arm even when idle, so a simultaneous arm is dropped
      if (i_cmd_abort) begin
        if (o_busy) r_state <= IDLE;
      end else if (i_cmd_arm && !o_busy) begin
        r_state <= ARMED;
        r_val   <= i_cfg_trig_val;
        r_mask  <= i_cfg_trig_mask;
        r_len   <= i_cfg_len;
        r_cnt   <= '0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (r_state == ARMED) begin
        if (r_len == '0) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else if (w_hit && bus.fifo_full) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_ovf   <= 1'b1;
        end else if (w_hit) begin
          r_fifo_wr   <= 1'b1;
          r_fifo_data <= bus.in_data;
          r_cnt       <= w_cnt_nxt;
          r_state     <= r_len == CNT_W'(1) ? DONE : CAPTURE;
          r_done      <= r_len == CNT_W'(1);
        end
      end else if (r_state == CAPTURE && bus.in_valid) begin
        if (bus.fifo_full) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_ovf   <= 1'b1;
        end else begin
          r_fifo_wr   <= 1'b1;
          r_fifo_data <= bus.in_data;
          r_cnt       <= w_cnt_nxt;
          r_state     <= w_cnt_nxt == r_len ? DONE : CAPTURE;
          r_done      <= w_cnt_nxt == r_len;
        end
      end
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed scenario tests for capture_ctrl with a FIFO write recorder
module tb_capture_ctrl;
  logic        clk = 1'b0;
  logic        rst, cmd_arm, cmd_abort;
  logic [31:0] cfg_val, cfg_mask;
  logic [15:0] cfg_len;
  logic        busy, done, overflow;
  logic [15:0] word_cnt;
  logic [31:0] cap_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  capture_ctrl_if #(.DATA_LEN(32)) bus ();

  capture_ctrl #(.DATA_LEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_cmd_arm(cmd_arm), .i_cmd_abort(cmd_abort),
    .i_cfg_trig_val(cfg_val), .i_cfg_trig_mask(cfg_mask), .i_cfg_len(cfg_len),
    .bus(bus), .o_busy(busy), .o_done(done), .o_overflow(overflow), .o_word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.fifo_wr === 1'b1) cap_q.push_back(bus.fifo_data);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [31:0] v, input logic [31:0] m, input logic [15:0] l);
    cfg_val = v; cfg_mask = m; cfg_len = l; cmd_arm = 1'b1;
    tick();
    cmd_arm = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d);
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic abort;
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bus.fifo_wr, bus.fifo_data, busy, done, overflow, word_cnt} !== 52'd0) begin
      n_err++; $display("FAIL reset_outputs got wr=%b data=%h busy=%b done=%b ovf=%b cnt=%0d exp all 0",
                        bus.fifo_wr, bus.fifo_data, busy, done, overflow, word_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    cap_q.delete();
    arm(32'h0, 32'h0, 16'd4);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy); end
    for (int i = 1; i <= 6; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if (cap_q.size() != 4) begin n_err++; $display("FAIL basic_count got %0d exp 4", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 4; i++) begin
      n_cmp++;
      if (cap_q[i] !== 32'(i + 1)) begin n_err++; $display("FAIL basic_word%0d got %h exp %h", i, cap_q[i], i + 1); end
    end
    n_cmp++;
    if ({done, busy, word_cnt} !== {1'b1, 1'b0, 16'd4}) begin
      n_err++; $display("FAIL basic_done got done=%b busy=%b cnt=%0d exp 1 0 4", done, busy, word_cnt);
    end
  endtask

  task automatic test_trigger;
    cap_q.delete();
    arm(32'hA500_0000, 32'hFF00_0000, 16'd3);
    n_cmp++;
    if ({busy, done, word_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      n_err++; $display("FAIL rearm_from_done got busy=%b done=%b cnt=%0d exp 1 0 0", busy, done, word_cnt);
    end
    cfg_val = 32'h0; cfg_mask = 32'hFFFF_FFFF;
    feed(32'h11);
    n_cmp++;
    if (bus.fifo_wr !== 1'b0) begin n_err++; $display("FAIL trig_nohit_wr got %b exp 0", bus.fifo_wr); end
    feed(32'hA500_0001);
    n_cmp++;
    if ({bus.fifo_wr, bus.fifo_data, word_cnt} !== {1'b1, 32'hA500_0001, 16'd1}) begin
      n_err++; $display("FAIL trig_first_write got wr=%b data=%h cnt=%0d exp 1 a5000001 1", bus.fifo_wr, bus.fifo_data, word_cnt);
    end
    feed(32'h22);
    n_cmp++;
    if ({bus.fifo_wr, bus.fifo_data, word_cnt} !== {1'b1, 32'h22, 16'd2}) begin
      n_err++; $display("FAIL trig_second_write got wr=%b data=%h cnt=%0d exp 1 00000022 2", bus.fifo_wr, bus.fifo_data, word_cnt);
    end
    abort();
  endtask

  task automatic test_overflow;
    cap_q.delete();
    arm(32'h0, 32'h0, 16'd8);
    feed(32'hB1); feed(32'hB2);
    bus.fifo_full = 1'b1;
    feed(32'hB3);
    n_cmp++;
    if ({bus.fifo_wr, overflow, done, busy, word_cnt} !== {4'b0110, 16'd2}) begin
      n_err++; $display("FAIL ovf_state got wr=%b ovf=%b done=%b busy=%b cnt=%0d exp 0 1 1 0 2",
                        bus.fifo_wr, overflow, done, busy, word_cnt);
    end
    bus.fifo_full = 1'b0;
    feed(32'hB4); feed(32'hB5); tick();
    n_cmp++;
    if (cap_q.size() != 2) begin n_err++; $display("FAIL ovf_writes got %0d exp 2", cap_q.size()); end
    cap_q.delete();
    arm(32'h0, 32'h0, 16'd5);
    bus.fifo_full = 1'b1;
    feed(32'hC1);
    bus.fifo_full = 1'b0;
    tick();
    n_cmp++;
    if ({cap_q.size() == 0, overflow, done, word_cnt} !== {3'b111, 16'd0}) begin
      n_err++; $display("FAIL ovf_trigger got writes=%0d ovf=%b done=%b cnt=%0d exp 0 1 1 0", cap_q.size(), overflow, done, word_cnt);
    end
  endtask

  task automatic test_abort;
    cap_q.delete();
    arm(32'h0, 32'h0, 16'd10);
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL arm_clears_ovf got %b exp 0", overflow); end
    feed(32'hD1); feed(32'hD2); feed(32'hD3);
    cmd_arm = 1'b1; cfg_len = 16'd1;
    feed(32'hD4);
    cmd_arm = 1'b0;
    n_cmp++;
    if ({busy, word_cnt} !== {1'b1, 16'd4}) begin
      n_err++; $display("FAIL arm_while_busy got busy=%b cnt=%0d exp 1 4", busy, word_cnt);
    end
    bus.in_valid = 1'b1; bus.in_data = 32'hD5;
    abort();
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.fifo_wr, busy, done, word_cnt} !== {3'b000, 16'd4}) begin
      n_err++; $display("FAIL abort_state got wr=%b busy=%b done=%b cnt=%0d exp 0 0 0 4", bus.fifo_wr, busy, done, word_cnt);
    end
    cap_q.delete();
    arm(32'h0, 32'h0, 16'd2);
    n_cmp++;
    if (word_cnt !== 16'd0) begin n_err++; $display("FAIL rearm_clear got %0d exp 0", word_cnt); end
    feed(32'hE1); feed(32'hE2); feed(32'hE3); tick();
    n_cmp++;
    if (cap_q.size() != 2 || cap_q[0] !== 32'hE1 || cap_q[1] !== 32'hE2 || done !== 1'b1 || word_cnt !== 16'd2) begin
      n_err++; $display("FAIL rearm_capture got writes=%0d done=%b cnt=%0d exp 2 (e1,e2) 1 2", cap_q.size(), done, word_cnt);
    end
    cap_q.delete();
    arm(32'h0, 32'h0, 16'd0);
    feed(32'hF1);
    n_cmp++;
    if ({done, busy, word_cnt, cap_q.size() == 0} !== {2'b10, 16'd0, 1'b1}) begin
      n_err++; $display("FAIL len_zero got done=%b busy=%b cnt=%0d writes=%0d exp 1 0 0 0", done, busy, word_cnt, cap_q.size());
    end
  endtask

  task automatic test_reset_mid;
    arm(32'h0, 32'h0, 16'd10);
    feed(32'h71); feed(32'h72);
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h73;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.fifo_wr, bus.fifo_data, busy, done, overflow, word_cnt} !== 52'd0) begin
      n_err++; $display("FAIL reset_mid got wr=%b data=%h busy=%b done=%b ovf=%b cnt=%0d exp all 0",
                        bus.fifo_wr, bus.fifo_data, busy, done, overflow, word_cnt);
    end
    cmd_arm = 1'b1; cmd_abort = 1'b1;
    tick();
    cmd_arm = 1'b0; cmd_abort = 1'b0;
    feed(32'h0);
    n_cmp++;
    if ({busy, done, bus.fifo_wr} !== 3'b000) begin
      n_err++; $display("FAIL arm_abort_idle got busy=%b done=%b wr=%b exp 0 0 0", busy, done, bus.fifo_wr);
    end
  endtask

  task automatic test_stream;
    logic [31:0] w;
    int          errs;
    cap_q.delete();
    arm(32'h0, 32'h0, 16'd850);
    for (int i = 0; i < 850; i++) begin
      w = (32'(i) * 32'h9E37_79B9) ^ (32'(i) << 20);
      if (i % 7 == 3) tick();
      feed(w);
    end
    tick(); tick();
    n_cmp++;
    if (cap_q.size() != 850) begin n_err++; $display("FAIL stream_count got %0d exp 850", cap_q.size()); end
    errs = 0;
    for (int i = 0; i < cap_q.size(); i++) begin
      w = (32'(i) * 32'h9E37_79B9) ^ (32'(i) << 20);
      if (cap_q[i] !== w) begin
        if (errs < 5) $display("FAIL stream_word%0d got %h exp %h", i, cap_q[i], w);
        errs++;
      end
    end
    n_cmp++;
    if (errs != 0) n_err++;
    n_cmp++;
    if ({done, busy, word_cnt} !== {2'b10, 16'd850}) begin
      n_err++; $display("FAIL stream_done got done=%b busy=%b cnt=%0d exp 1 0 850", done, busy, word_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_arm = 1'b0; cmd_abort = 1'b0;
    cfg_val = '0; cfg_mask = '0; cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_trigger();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
